// File: rtl/wb_uart_pkg.sv
// ---- wb_uart_pkg : FSM state type and 16550 register offsets  (rev 1.0) ----
`default_nettype none

package wb_uart_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // 16550 register offsets; shared offsets are distinguished by direction or DLAB
   localparam logic [2:0] RBR = 3'd0;
   localparam logic [2:0] THR = 3'd0;
   localparam logic [2:0] IER = 3'd1;
   localparam logic [2:0] IIR = 3'd2;
   localparam logic [2:0] FCR = 3'd2;
   localparam logic [2:0] LCR = 3'd3;
   localparam logic [2:0] MCR = 3'd4;
   localparam logic [2:0] LSR = 3'd5;
   localparam logic [2:0] MSR = 3'd6;
   localparam logic [2:0] SCR = 3'd7;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
// ---- wb_timeout_cnt : bus-cycle watchdog, fires on the TIMEOUT-th unacked cycle  (rev 1.0) ----
`default_nettype none

module wb_timeout_cnt
   import wb_uart_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic nrst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] C_TC = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i && !tc_o) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // en_i is low on an acked cycle, so an ack on the terminal cycle masks the timeout
   assign tc_o = en_i && (r_cnt == C_TC);

endmodule

`default_nettype wire

// File: rtl/wb_uart_master.sv
// ---- wb_uart_master : single-outstanding Wishbone master for a 16550-style UART  (rev 1.0) ----
`default_nettype none

module wb_uart_master
   import wb_uart_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int ADR_W   = 32
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_we_i,
   input  logic [ADR_W-1:0] cmd_adr_i,
   input  logic [31:0]      cmd_dat_i,
   input  logic [3:0]       cmd_sel_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_dat_o,
   output logic             rsp_err_o,
   output logic [ADR_W-1:0] wb_adr_o,
   output logic [31:0]      wb_dat_o,
   output logic             wb_we_o,
   output logic [3:0]       wb_sel_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i,
   input  logic             wb_intr_i,
   output logic             irq_o
);

   state_t           r_state;
   state_t           w_next;
   logic             w_accept;
   logic             w_done_ack;
   logic             w_done_to;
   logic             w_tc;
   logic             r_cyc;
   logic             r_we;
   logic [ADR_W-1:0] r_adr;
   logic [31:0]      r_dat;
   logic [3:0]       r_sel;
   logic [31:0]      r_rsp_dat;
   logic             r_rsp_err;
   logic             r_irq_meta;
   logic             r_irq;

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .clr_i  (w_accept),
      .en_i   ((r_state == BUS) && !wb_ack_i),
      .tc_o   (w_tc)
   );

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_done_ack = 1'b0;
      w_done_to  = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid_i) begin
               w_accept = 1'b1;
               w_next   = BUS;
            end
         end
         BUS: begin
            if (wb_ack_i) begin
               w_done_ack = 1'b1;
               w_next     = RESP;
            end else if (w_tc) begin
               w_done_to = 1'b1;
               w_next    = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_rsp_dat <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cyc <= 1'b1;
            r_we  <= cmd_we_i;
            r_adr <= cmd_adr_i;
            r_dat <= cmd_dat_i;
            r_sel <= cmd_sel_i;
         end
         if (w_done_ack) begin
            r_cyc     <= 1'b0;
            r_rsp_dat <= r_we ? 32'd0 : wb_dat_i;
            r_rsp_err <= 1'b0;
         end
         if (w_done_to) begin
            r_cyc     <= 1'b0;
            r_rsp_dat <= 32'd0;
            r_rsp_err <= 1'b1;
         end
      end
   end

   // Interrupt crosses from the slave through a two-flop stage
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_irq_meta <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_irq_meta <= wb_intr_i;
         r_irq      <= r_irq_meta;
      end
   end

   assign cmd_ready_o = (r_state == IDLE);
   assign rsp_valid_o = (r_state == RESP);
   assign rsp_dat_o   = r_rsp_dat;
   assign rsp_err_o   = r_rsp_err;
   assign wb_adr_o    = r_adr;
   assign wb_dat_o    = r_dat;
   assign wb_we_o     = r_we;
   assign wb_sel_o    = r_sel;
   assign wb_cyc_o    = r_cyc;
   assign wb_stb_o    = r_cyc;
   assign irq_o       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_master.sv
// ---- tb_wb_uart_master : directed bench with a transaction-level reference model  (rev 1.0) ----
`default_nettype none

module tb_wb_uart_master;

   localparam int TIMEOUT = 4;
   localparam int ADR_W   = 32;

   logic             clk = 1'b0;
   logic             nrst_i;
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic             cmd_we_i;
   logic [ADR_W-1:0] cmd_adr_i;
   logic [31:0]      cmd_dat_i;
   logic [3:0]       cmd_sel_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [31:0]      rsp_dat_o;
   logic             rsp_err_o;
   logic [ADR_W-1:0] wb_adr_o;
   logic [31:0]      wb_dat_o;
   logic             wb_we_o;
   logic [3:0]       wb_sel_o;
   logic             wb_cyc_o;
   logic             wb_stb_o;
   logic [31:0]      wb_dat_i;
   logic             wb_ack_i;
   logic             wb_intr_i;
   logic             irq_o;

   always #5 clk = ~clk;

   wb_uart_master #(
      .TIMEOUT (TIMEOUT),
      .ADR_W   (ADR_W)
   ) dut (
      .clk_i       (clk),
      .nrst_i      (nrst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_adr_i   (cmd_adr_i),
      .cmd_dat_i   (cmd_dat_i),
      .cmd_sel_i   (cmd_sel_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_dat_o   (rsp_dat_o),
      .rsp_err_o   (rsp_err_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o),
      .wb_we_o     (wb_we_o),
      .wb_sel_o    (wb_sel_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i),
      .wb_intr_i   (wb_intr_i),
      .irq_o       (irq_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: one outstanding transaction, cyc lasts until ack or the TIMEOUT-th cycle
   logic        m_started = 1'b0;
   logic        m_cyc = 1'b0, m_rsp = 1'b0, m_err = 1'b0, m_we = 1'b0;
   int          m_age = 0;
   logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
   logic [3:0]  m_sel = '0;
   logic        m_irq0 = 1'b0, m_irq = 1'b0;

   always @(posedge clk) begin
      m_started <= 1'b1;
      m_irq0    <= nrst_i ? wb_intr_i : 1'b0;
      m_irq     <= nrst_i ? m_irq0 : 1'b0;
      if (!nrst_i) begin
         m_cyc <= 1'b0; m_rsp <= 1'b0; m_err <= 1'b0; m_we <= 1'b0; m_age <= 0;
         m_adr <= '0;   m_dat <= '0;   m_sel <= '0;   m_rdat <= '0;
      end else if (!m_cyc && !m_rsp) begin
         if (cmd_valid_i) begin
            m_cyc <= 1'b1; m_age <= 1;
            m_we <= cmd_we_i; m_adr <= cmd_adr_i; m_dat <= cmd_dat_i; m_sel <= cmd_sel_i;
         end
      end else if (m_cyc) begin
         if (wb_ack_i) begin
            m_cyc <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b0;
            m_rdat <= m_we ? 32'd0 : wb_dat_i;
         end else if (m_age == TIMEOUT) begin
            m_cyc <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b1; m_rdat <= 32'd0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (rsp_ready_i) begin
         m_rsp <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("cmd_ready", cmd_ready_o, !m_cyc && !m_rsp);
         check("wb_cyc", wb_cyc_o, m_cyc);
         check("wb_stb", wb_stb_o, m_cyc);
         check("rsp_valid", rsp_valid_o, m_rsp);
         check("wb_we", wb_we_o, m_we);
         check("wb_adr", wb_adr_o, m_adr);
         check("wb_dat", wb_dat_o, m_dat);
         check("wb_sel", wb_sel_o, m_sel);
         check("irq", irq_o, m_irq);
         if (m_rsp) begin
            check("rsp_dat", rsp_dat_o, m_rdat);
            check("rsp_err", rsp_err_o, m_err);
         end
      end
   end

   // Slave: acks on the s_ack_at-th cycle of cyc (0 = never); monitors pulse length and lanes
   int          s_ack_at = 0;
   int          s_cnt = 0;
   logic [31:0] s_rdata = '0;
   logic        s_force_ack = 1'b0;
   int          cyc_len = 0;
   logic        seen_we = 1'b0;
   logic [3:0]  seen_sel = '0;

   always @(negedge clk) begin
      if (wb_cyc_o) begin
         s_cnt    = s_cnt + 1;
         cyc_len  = cyc_len + 1;
         seen_we  = wb_we_o;
         seen_sel = wb_sel_o;
      end else begin
         s_cnt = 0;
      end
      wb_ack_i = s_force_ack || (wb_cyc_o && s_ack_at != 0 && s_cnt == s_ack_at);
      wb_dat_i = wb_ack_i ? s_rdata : 32'hDEAD_BEEF;
   end

   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                         input int hold, output logic [31:0] o_dat, output logic o_err,
                         output int o_len);
      int i;
      @(negedge clk);
      s_ack_at = ack_at; s_rdata = rdata; cyc_len = 0;
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      i = 0;
      while (!rsp_valid_o && i < 40) begin
         @(negedge clk);
         i++;
      end
      o_dat = rsp_dat_o; o_err = rsp_err_o; o_len = cyc_len;
      if (!rsp_valid_o) begin
         check("rsp_arrive", 1'b0, 1'b1);
         return;
      end
      for (int k = 0; k < hold; k++) begin
         check("hold_cmd_ready", cmd_ready_o, 1'b0);
         check("hold_rsp_dat", rsp_dat_o, rdata);
         check("hold_rsp_valid", rsp_valid_o, 1'b1);
         @(negedge clk);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
   endtask

   logic [31:0] r_dat;
   logic        r_err;
   int          r_len;
   int          n_rsp;

   initial begin
      nrst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0;
      cmd_dat_i = '0; cmd_sel_i = '0; rsp_ready_i = 1'b0; wb_intr_i = 1'b1;
      wb_ack_i = 1'b0; wb_dat_i = '0;
      repeat (3) @(negedge clk);
      check("reset_cyc", wb_cyc_o, 1'b0);
      check("reset_irq", irq_o, 1'b0);
      check("reset_rsp_valid", rsp_valid_o, 1'b0);
      nrst_i = 1'b1; wb_intr_i = 1'b0;
      @(negedge clk);
      check("ready_after_reset", cmd_ready_o, 1'b1);

      // Write LCR = 0x83, ack on 2nd bus cycle
      do_cmd(1'b1, 32'd3, 32'h83, 4'h1, 2, 32'hFFFF_FFFF, 0, r_dat, r_err, r_len);
      check("lcr_cyc_len", r_len, 2);
      check("lcr_we", seen_we, 1'b1);
      check("lcr_sel", seen_sel, 4'h1);
      check("lcr_err", r_err, 1'b0);
      check("lcr_dat", r_dat, 32'd0);

      // Read LSR, minimum latency
      do_cmd(1'b0, 32'd5, 32'd0, 4'h1, 1, 32'h60, 0, r_dat, r_err, r_len);
      check("lsr_dat", r_dat, 32'h60);
      check("lsr_err", r_err, 1'b0);
      check("lsr_cyc_len", r_len, 1);

      // Slave never acks
      do_cmd(1'b0, 32'd6, 32'd0, 4'hF, 0, 32'h0, 0, r_dat, r_err, r_len);
      check("tmo_cyc_len", r_len, TIMEOUT);
      check("tmo_err", r_err, 1'b1);
      check("tmo_dat", r_dat, 32'd0);

      // Ack coincides with the terminal-count cycle
      do_cmd(1'b0, 32'd7, 32'd0, 4'h1, TIMEOUT, 32'hA5A5_0001, 0, r_dat, r_err, r_len);
      check("tie_err", r_err, 1'b0);
      check("tie_dat", r_dat, 32'hA5A5_0001);
      check("tie_cyc_len", r_len, TIMEOUT);

      // Response held while the consumer stalls
      do_cmd(1'b0, 32'd2, 32'd0, 4'h1, 3, 32'h0000_1234, 10, r_dat, r_err, r_len);
      check("stall_dat", r_dat, 32'h1234);

      // Ack outside BUS must be ignored
      @(negedge clk);
      s_force_ack = 1'b1; s_rdata = 32'h5555_5555;
      repeat (3) begin
         @(negedge clk);
         check("stray_ack_rsp", rsp_valid_o, 1'b0);
         check("stray_ack_ready", cmd_ready_o, 1'b1);
      end
      s_force_ack = 1'b0;

      // Back-to-back: three transactions in nine cycles
      @(negedge clk);
      s_ack_at = 1; s_rdata = 32'h0000_00AB; n_rsp = 0;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'd0; cmd_sel_i = 4'h1;
      rsp_ready_i = 1'b1;
      repeat (9) begin
         @(negedge clk);
         if (rsp_valid_o) n_rsp++;
      end
      cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
      check("b2b_count", n_rsp, 3);

      // Reset pulsed during BUS
      @(negedge clk);
      s_ack_at = 0; cyc_len = 0;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'd1; cmd_dat_i = 32'h0F; cmd_sel_i = 4'h1;
      @(negedge clk);
      cmd_valid_i = 1'b0;
      check("mid_bus_cyc", wb_cyc_o, 1'b1);
      @(negedge clk);
      nrst_i = 1'b0;
      @(negedge clk);
      check("rst_drop_cyc", wb_cyc_o, 1'b0);
      check("rst_drop_stb", wb_stb_o, 1'b0);
      nrst_i = 1'b1;
      @(negedge clk);
      check("rst_release_ready", cmd_ready_o, 1'b1);
      repeat (6) begin
         @(negedge clk);
         check("rst_no_rsp", rsp_valid_o, 1'b0);
      end

      // Interrupt passes through two flops
      wb_intr_i = 1'b1;
      @(negedge clk);
      check("irq_stage1", irq_o, 1'b0);
      @(negedge clk);
      check("irq_stage2", irq_o, 1'b1);
      wb_intr_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
